// File: rtl/apb_master_arb_if.sv
// Bundle of requester-side and APB-side signals for apb_master_arb.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_master_arb_if #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_write;
    logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [APB_DATA_WIDTH-1:0]         rsp_rdata;
    logic                              busy;

    logic [APB_ADDR_WIDTH-1:0]         PAddr;
    logic                              PSel;
    logic                              PEnable;
    logic                              PWrite;
    logic [APB_DATA_WIDTH-1:0]         PWData;
    logic [APB_DATA_WIDTH-1:0]         PRData;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRData,
        output req_ready, rsp_valid, rsp_rdata, busy,
               PAddr, PSel, PEnable, PWrite, PWData
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRData,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               PAddr, PSel, PEnable, PWrite, PWData
    );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin arbiter sharing one APB bus among NUM_REQ requesters.
// Sequences SETUP/ACCESS, captures PRData and returns a one-cycle completion pulse.
module apb_master_arb #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 32
) (
    input  logic             PClk,
    input  logic             Rst_n,
    apb_master_arb_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [IDX_W-1:0]          r_ptr;
    logic [IDX_W-1:0]          r_cur_idx;
    logic [IDX_W-1:0]          w_gnt_idx;
    logic                      w_any_req;
    logic                      w_grant;
    logic [NUM_REQ-1:0]        w_gnt_oh;
    logic [2*NUM_REQ-1:0]      w_req_dbl;
    logic [NUM_REQ-1:0]        w_rot;
    logic [IDX_W:0]            w_shift;
    logic [IDX_W+1:0]          w_sum;

    logic [APB_ADDR_WIDTH-1:0] w_sel_addr;
    logic [APB_DATA_WIDTH-1:0] w_sel_wdata;
    logic                      w_sel_write;

    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                      w_psel;
    logic                      w_penable;

    // Rotate the request vector so bit 0 is the requester just after the
    // last grant; the lowest set bit of the rotated vector wins.
    always_comb begin
        w_any_req = |bus.req_valid;
        w_shift   = {1'b0, r_ptr} + (IDX_W+1)'(1);
        w_req_dbl = {bus.req_valid, bus.req_valid};
        w_rot     = NUM_REQ'(w_req_dbl >> w_shift);
        w_sum     = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_sum = (IDX_W+2)'(w_shift) + (IDX_W+2)'(j);
            end
        end
        if (w_sum >= (IDX_W+2)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W+2)'(NUM_REQ);
        end
        w_gnt_idx = w_sum[IDX_W-1:0];
    end

    // Grants happen only where a new SETUP may follow: from IDLE or ACCESS.
    always_comb begin
        w_grant  = Rst_n && w_any_req && (r_state != ST_SETUP);
        w_gnt_oh = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_addr  = bus.req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                w_sel_write = bus.req_write[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge PClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = w_any_req ? ST_SETUP : ST_IDLE;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = w_any_req ? ST_SETUP : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        w_penable = (r_state == ST_ACCESS);
    end

    // Payload, pointer and response registers; bus payload holds between transfers.
    always_ff @(posedge PClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_cur_idx   <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_state == ST_ACCESS) begin
                r_rsp_valid <= NUM_REQ'(1) << r_cur_idx;
                r_rsp_rdata <= r_pwrite ? '0 : bus.PRData;
            end
            if (w_grant) begin
                r_ptr     <= w_gnt_idx;
                r_cur_idx <= w_gnt_idx;
                r_paddr   <= w_sel_addr;
                r_pwdata  <= w_sel_wdata;
                r_pwrite  <= w_sel_write;
            end
        end
    end

    assign bus.req_ready = w_gnt_oh;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.busy      = w_psel;
    assign bus.PAddr     = r_paddr;
    assign bus.PSel      = w_psel;
    assign bus.PEnable   = w_penable;
    assign bus.PWrite    = r_pwrite;
    assign bus.PWData    = r_pwdata;
endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: a 2-requester and a 4-requester instance
// driven on the falling edge and sampled 1 ns later.
module tb_apb_master_arb;
    logic PClk = 1'b0;
    logic Rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [1:0]  exp_ready2;
    logic [1:0]  exp_rsp2;
    logic        exp_psel;
    logic        exp_pen;
    logic [15:0] exp_addr;

    always #5 PClk = ~PClk;

    apb_master_arb_if #(.NUM_REQ(2), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(32)) bus2 ();
    apb_master_arb_if #(.NUM_REQ(4), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(32)) bus4 ();

    apb_master_arb #(.NUM_REQ(2), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(32)) u_dut2 (
        .PClk  (PClk),
        .Rst_n (Rst_n),
        .bus   (bus2.master)
    );

    apb_master_arb #(.NUM_REQ(4), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(32)) u_dut4 (
        .PClk  (PClk),
        .Rst_n (Rst_n),
        .bus   (bus4.master)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n          = 1'b0;
        bus2.req_valid = '0;
        bus2.req_write = '0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus2.PRData    = '0;
        bus4.req_valid = '0;
        bus4.req_write = '0;
        bus4.req_addr  = '0;
        bus4.req_wdata = '0;
        bus4.PRData    = '0;

        // Reset state, with requests pending that must not be accepted.
        repeat (2) @(negedge PClk);
        bus2.req_valid = 2'b01;
        bus4.req_valid = 4'b1111;
        #1;
        check("rst_psel",    bus2.PSel,      0);
        check("rst_penable", bus2.PEnable,   0);
        check("rst_paddr",   bus2.PAddr,     0);
        check("rst_pwrite",  bus2.PWrite,    0);
        check("rst_pwdata",  bus2.PWData,    0);
        check("rst_busy",    bus2.busy,      0);
        check("rst_rsp",     bus2.rsp_valid, 0);
        check("rst_rdata",   bus2.rsp_rdata, 0);
        check("rst_ready2",  bus2.req_ready, 0);
        check("rst_ready4",  bus4.req_ready, 0);
        @(negedge PClk);
        bus2.req_valid = '0;
        bus4.req_valid = '0;
        Rst_n          = 1'b1;

        // Single write from requester 0.
        @(negedge PClk);
        bus2.req_valid = 2'b01;
        bus2.req_write = 2'b01;
        bus2.req_addr  = {16'h0000, 16'h0010};
        bus2.req_wdata = {32'h0000_0000, 32'hDEAD_BEEF};
        #1;
        check("wr_ready",  bus2.req_ready, 2'b01);
        check("wr_idle_psel", bus2.PSel, 0);
        @(negedge PClk);
        bus2.req_valid = 2'b00;
        #1;
        check("wr_setup_psel", bus2.PSel,    1);
        check("wr_setup_pen",  bus2.PEnable, 0);
        check("wr_setup_busy", bus2.busy,    1);
        @(negedge PClk);
        #1;
        check("wr_acc_psel",   bus2.PSel,      1);
        check("wr_acc_pen",    bus2.PEnable,   1);
        check("wr_acc_pwrite", bus2.PWrite,    1);
        check("wr_acc_paddr",  bus2.PAddr,     16'h0010);
        check("wr_acc_pwdata", bus2.PWData,    32'hDEAD_BEEF);
        check("wr_acc_rsp",    bus2.rsp_valid, 0);
        @(negedge PClk);
        #1;
        check("wr_rsp",   bus2.rsp_valid, 2'b01);
        check("wr_rdata", bus2.rsp_rdata, 0);
        check("wr_done_psel", bus2.PSel, 0);

        // Single read from requester 1.
        @(negedge PClk);
        bus2.req_valid = 2'b10;
        bus2.req_write = 2'b00;
        bus2.req_addr  = {16'h0020, 16'h0010};
        bus2.PRData    = 32'h1234_5678;
        #1;
        check("rd_ready", bus2.req_ready, 2'b10);
        @(negedge PClk);
        bus2.req_valid = 2'b00;
        #1;
        check("rd_setup_pen",    bus2.PEnable, 0);
        check("rd_setup_pwrite", bus2.PWrite,  0);
        check("rd_setup_paddr",  bus2.PAddr,   16'h0020);
        @(negedge PClk);
        #1;
        check("rd_acc_pen",    bus2.PEnable, 1);
        check("rd_acc_pwrite", bus2.PWrite,  0);
        @(negedge PClk);
        #1;
        check("rd_rsp",   bus2.rsp_valid, 2'b10);
        check("rd_rdata", bus2.rsp_rdata, 32'h1234_5678);

        // Fair rotation: both requesters continuously valid for six writes.
        @(negedge PClk);
        bus2.PRData    = 32'hFFFF_FFFF;
        bus2.req_valid = 2'b11;
        bus2.req_write = 2'b11;
        bus2.req_addr  = {16'h0200, 16'h0100};
        bus2.req_wdata = {32'h2222_2222, 32'h1111_1111};
        for (int t = 0; t <= 13; t++) begin
            if (t > 0) @(negedge PClk);
            if (t == 11) bus2.req_valid = 2'b00;
            #1;
            exp_ready2 = (t % 2 == 0 && t <= 10) ? (((t / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_psel   = (t >= 1 && t <= 12);
            exp_pen    = (t % 2 == 0 && t >= 2 && t <= 12);
            exp_rsp2   = (t % 2 == 1 && t >= 3) ? ((((t - 3) / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("rot_ready_t%0d", t), bus2.req_ready, exp_ready2);
            check($sformatf("rot_psel_t%0d", t),  bus2.PSel,      exp_psel);
            check($sformatf("rot_pen_t%0d", t),   bus2.PEnable,   exp_pen);
            check($sformatf("rot_rsp_t%0d", t),   bus2.rsp_valid, exp_rsp2);
            if (exp_pen) begin
                exp_addr = (((t - 2) / 2) % 2 == 0) ? 16'h0100 : 16'h0200;
                check($sformatf("rot_paddr_t%0d", t), bus2.PAddr, exp_addr);
            end
            if (exp_rsp2 != 2'b00) begin
                check($sformatf("rot_rdata_t%0d", t), bus2.rsp_rdata, 0);
            end
        end

        // Reset during ACCESS: bus drops at once and no completion follows.
        @(negedge PClk);
        bus2.req_valid = 2'b01;
        bus2.req_write = 2'b00;
        bus2.req_addr  = {16'h0000, 16'h0040};
        bus2.PRData    = 32'hBAD0_BAD0;
        #1;
        check("mid_ready", bus2.req_ready, 2'b01);
        @(negedge PClk);
        bus2.req_valid = 2'b00;
        @(negedge PClk);
        #1;
        check("mid_acc_pen", bus2.PEnable, 1);
        Rst_n = 1'b0;
        #1;
        check("mid_rst_psel",  bus2.PSel,    0);
        check("mid_rst_pen",   bus2.PEnable, 0);
        check("mid_rst_busy",  bus2.busy,    0);
        check("mid_rst_paddr", bus2.PAddr,   0);
        @(negedge PClk);
        #1;
        check("mid_rst_rsp",   bus2.rsp_valid, 0);
        check("mid_rst_rdata", bus2.rsp_rdata, 0);

        // Release with requester 0 writing 0x0030, then hold idle.
        @(negedge PClk);
        Rst_n          = 1'b1;
        bus2.req_valid = 2'b01;
        bus2.req_write = 2'b01;
        bus2.req_addr  = {16'h0000, 16'h0030};
        bus2.req_wdata = {32'h0000_0000, 32'hCAFE_0030};
        #1;
        check("post_ready", bus2.req_ready, 2'b01);
        @(negedge PClk);
        bus2.req_valid = 2'b00;
        #1;
        check("post_setup_psel",  bus2.PSel,    1);
        check("post_setup_pen",   bus2.PEnable, 0);
        check("post_setup_paddr", bus2.PAddr,   16'h0030);
        @(negedge PClk);
        #1;
        check("post_acc_pen", bus2.PEnable, 1);
        @(negedge PClk);
        #1;
        check("post_rsp", bus2.rsp_valid, 2'b01);
        for (int i = 0; i < 10; i++) begin
            @(negedge PClk);
            #1;
            check($sformatf("idle_psel_%0d", i),  bus2.PSel,      0);
            check($sformatf("idle_busy_%0d", i),  bus2.busy,      0);
            check($sformatf("idle_paddr_%0d", i), bus2.PAddr,     16'h0030);
            check($sformatf("idle_rsp_%0d", i),   bus2.rsp_valid, 0);
        end

        // Four requesters: reset pointer favours 0, then 3.
        bus4.req_write = 4'b1101;
        bus4.req_addr  = {16'h3333, 16'h2222, 16'h1111, 16'h0A00};
        bus4.req_wdata = {32'h3, 32'h2, 32'h1, 32'h0};
        bus4.PRData    = 32'hA5A5_0001;
        @(negedge PClk);
        bus4.req_valid = 4'b1001;
        #1;
        check("q_a_ready0", bus4.req_ready, 4'b0001);
        @(negedge PClk);
        bus4.req_valid = 4'b1000;
        #1;
        check("q_a_setup_ready", bus4.req_ready, 4'b0000);
        check("q_a_setup_paddr", bus4.PAddr,     16'h0A00);
        @(negedge PClk);
        #1;
        check("q_a_acc_pen", bus4.PEnable,   1);
        check("q_a_ready3",  bus4.req_ready, 4'b1000);
        @(negedge PClk);
        bus4.req_valid = 4'b0000;
        #1;
        check("q_a_rsp0",   bus4.rsp_valid, 4'b0001);
        check("q_a_paddr3", bus4.PAddr,     16'h3333);
        check("q_a_b2b_psel", bus4.PSel,    1);
        @(negedge PClk);
        #1;
        check("q_a_acc2_ready", bus4.req_ready, 4'b0000);
        @(negedge PClk);
        #1;
        check("q_a_rsp3",  bus4.rsp_valid, 4'b1000);
        check("q_a_psel0", bus4.PSel,      0);

        // Pointer fairness: after a grant to 2, requester 3 beats requester 1.
        @(negedge PClk);
        bus4.req_valid = 4'b0100;
        #1;
        check("q_b_ready2", bus4.req_ready, 4'b0100);
        @(negedge PClk);
        bus4.req_valid = 4'b1010;
        #1;
        check("q_b_setup_ready", bus4.req_ready, 4'b0000);
        check("q_b_paddr2",      bus4.PAddr,     16'h2222);
        @(negedge PClk);
        #1;
        check("q_b_ready3", bus4.req_ready, 4'b1000);
        @(negedge PClk);
        bus4.req_valid = 4'b0010;
        #1;
        check("q_b_rsp2",   bus4.rsp_valid, 4'b0100);
        check("q_b_paddr3", bus4.PAddr,     16'h3333);
        @(negedge PClk);
        #1;
        check("q_b_ready1", bus4.req_ready, 4'b0010);
        @(negedge PClk);
        bus4.req_valid = 4'b0000;
        #1;
        check("q_b_rsp3",    bus4.rsp_valid, 4'b1000);
        check("q_b_paddr1",  bus4.PAddr,     16'h1111);
        check("q_b_pwrite1", bus4.PWrite,    0);
        @(negedge PClk);
        #1;
        check("q_b_acc_pen", bus4.PEnable, 1);
        @(negedge PClk);
        #1;
        check("q_b_rsp1",   bus4.rsp_valid, 4'b0010);
        check("q_b_rdata1", bus4.rsp_rdata, 32'hA5A5_0001);
        check("q_b_psel0",  bus4.PSel,      0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
